// File: rtl/cpu_host_loader.sv
// rtl/cpu_host_loader.sv - host-side loader that programs, runs and dumps a CPU core
//
// Ports:
//   clk, arst                    clock, asynchronous active-high reset
//   start                        command pulse, sampled only in IDLE
//   imem_count, run_cycles,      words to load, cycles to run, words to dump
//   dump_count                   (all latched on an accepted start)
//   s_valid/s_ready/s_data       32-bit instruction-word input stream
//   m_valid/m_ready/m_data       64-bit data-word output stream
//   busy, done                   sequence active / one-cycle completion pulse
//   cpu_arst_n, cpu_enable       CPU reset (active low) and CPU clock enable
//   addr_ext..wdata_ext          CPU instruction-memory external port
//   addr_ext_2..rdata_ext_2      CPU data-memory external port
module cpu_host_loader #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128,
    parameter int CYC_W      = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [7:0]       imem_count,
    input  logic [CYC_W-1:0] run_cycles,
    input  logic [7:0]       dump_count,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic             busy,
    output logic             done,
    output logic             cpu_arst_n,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2
);

    // Counts arrive on 8-bit inputs, so the clamp limits never exceed 255.
    localparam logic [7:0] IMEM_LIM = (IMEM_WORDS > 255) ? 8'd255 : 8'(IMEM_WORDS);
    localparam logic [7:0] DMEM_LIM = (DMEM_WORDS > 255) ? 8'd255 : 8'(DMEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP_RD,
        DUMP_CAP,
        DUMP_OUT,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       imem_n_q, imem_n_d;
    logic [7:0]       dump_n_q, dump_n_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [7:0]       widx_q, widx_d;
    logic [7:0]       ridx_q, ridx_d;

    logic             wen_d;
    logic [63:0]      addr_d;
    logic [31:0]      wdata_d;
    logic [63:0]      addr2_d;
    logic [63:0]      m_data_d;
    logic             s_ready_d;
    state_t           after_load;
    state_t           after_run;

    // The CPU never writes back through these paths and instruction memory is never read.
    assign ren_ext     = 1'b0;
    assign wen_ext_2   = 1'b0;
    assign wdata_ext_2 = 64'd0;

    // Zero-length phases are skipped entirely so no spurious enable or dump cycle appears.
    always_comb begin
        after_run = (dump_n_q != 8'd0) ? DUMP_RD : FIN;
        if (cyc_q != '0) begin
            after_load = RUN;
        end else begin
            after_load = after_run;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_n_d = imem_n_q;
        dump_n_d = dump_n_q;
        cyc_d    = cyc_q;
        widx_d   = widx_q;
        ridx_d   = ridx_q;
        wen_d    = 1'b0;
        addr_d   = addr_ext;
        wdata_d  = wdata_ext;
        addr2_d  = addr_ext_2;
        m_data_d = m_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    imem_n_d = (imem_count > IMEM_LIM) ? IMEM_LIM : imem_count;
                    dump_n_d = (dump_count > DMEM_LIM) ? DMEM_LIM : dump_count;
                    cyc_d    = run_cycles;
                    widx_d   = 8'd0;
                    ridx_d   = 8'd0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (widx_q >= imem_n_q) begin
                    state_d = after_load;
                end else if (s_ready && s_valid) begin
                    wen_d   = 1'b1;
                    addr_d  = {54'd0, widx_q, 2'b00};
                    wdata_d = s_data;
                    widx_d  = widx_q + 8'd1;
                    if (widx_q + 8'd1 == imem_n_q) begin
                        state_d = after_load;
                    end
                end
            end
            RUN: begin
                // Leaving when the counter holds 1 gives exactly run_cycles RUN cycles.
                if (cyc_q[CYC_W-1:1] == '0) begin
                    cyc_d   = '0;
                    state_d = after_run;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            DUMP_RD: begin
                state_d = DUMP_CAP;
            end
            DUMP_CAP: begin
                m_data_d = rdata_ext_2;
                state_d  = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (m_ready) begin
                    ridx_d  = ridx_q + 8'd1;
                    state_d = (ridx_q + 8'd1 == dump_n_q) ? FIN : DUMP_RD;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DUMP_RD) begin
            addr2_d = {53'd0, ridx_d, 3'b000};
        end
        s_ready_d = (state_d == LOAD) && (widx_d < imem_n_d);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            imem_n_q   <= 8'd0;
            dump_n_q   <= 8'd0;
            cyc_q      <= '0;
            widx_q     <= 8'd0;
            ridx_q     <= 8'd0;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= 64'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_arst_n <= 1'b0;
            cpu_enable <= 1'b0;
            addr_ext   <= 64'd0;
            wen_ext    <= 1'b0;
            wdata_ext  <= 32'd0;
            addr_ext_2 <= 64'd0;
            ren_ext_2  <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_n_q   <= imem_n_d;
            dump_n_q   <= dump_n_d;
            cyc_q      <= cyc_d;
            widx_q     <= widx_d;
            ridx_q     <= ridx_d;
            s_ready    <= s_ready_d;
            m_valid    <= (state_d == DUMP_OUT);
            m_data     <= m_data_d;
            busy       <= (state_d != IDLE);
            done       <= (state_d == FIN);
            cpu_arst_n <= !((state_d == IDLE) || (state_d == LOAD));
            cpu_enable <= (state_d == RUN);
            addr_ext   <= addr_d;
            wen_ext    <= wen_d;
            wdata_ext  <= wdata_d;
            addr_ext_2 <= addr2_d;
            ren_ext_2  <= (state_d == DUMP_RD);
        end
    end

endmodule
